seq_detect_ctrl: RTL and testbench

Programmable controller for the serial "1, N zeros, 1" pattern detector, the configurable successor to the fixed 10000001 detector. It accepts a zero-run length N and a match limit through a valid/ready configuration port. On `start` it sequences the zero-run counter over the synchronized serial input `J`, pulses `Y` on each match (overlapping patterns allowed), and stops after the programmed number of matches or on `abort`. It sits between the serial input pin logic and the system control FSM that arms detection runs.

---
 rtl/seq_detect_ctrl.sv | 138 +++++++++++++
 tb/tb_seq_detect_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable "1, N zeros, 1" serial pattern detector controller.
//
// A configuration (zero-run length N and a match limit) is accepted over a valid/ready
// port while idle. On start the FSM hunts for an opening 1, counts the following zeros
// and flags a match when a 1 arrives after exactly N zeros. The closing 1 of a match is
// reused as the next opening 1, so overlapping patterns are detected. The run stops
// after the programmed number of matches (0 = unlimited) or on abort.
//
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   J           raw serial input, one bit per clock (synchronized internally)
//   cfg_valid   configuration offered; cfg_ready high while idle
//   cfg_zeros   N, required zeros between the two 1s (N = 0 is rejected)
//   cfg_limit   matches before auto-stop, 0 = unlimited
//   cfg_err     last accepted configuration had N = 0 (sticky)
//   start       single-cycle arm request, abort returns to idle
//   busy        run in progress
//   Y           one-cycle match pulse
//   done        one-cycle pulse on the match that reaches the limit
//   match_cnt   matches since the last accepted start
module seq_detect_ctrl #(
  parameter int unsigned CW = 3,
  parameter int unsigned MW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          J,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_zeros,
  input  logic [MW-1:0] cfg_limit,
  output logic          cfg_err,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          Y,
  output logic          done,
  output logic [MW-1:0] match_cnt
);

  typedef enum logic [2:0] {StIdle, StHunt, StSeen1, StCount, StHit} state_e;

  state_e        state;
  logic          j_s;
  logic [CW-1:0] zcnt;
  logic [CW-1:0] zeros;
  logic [MW-1:0] limit;
  logic          cfg_ok;
  logic [MW:0]   match_inc;
  logic          hit_next_done;
  logic          cfg_take;

  assign cfg_ready = (state == StIdle);
  assign busy      = (state != StIdle);
  assign cfg_take  = cfg_valid && cfg_ready;

  // One bit wider than match_cnt so saturation and the limit compare see the carry.
  assign match_inc     = {1'b0, match_cnt} + {{MW{1'b0}}, 1'b1};
  assign hit_next_done = (limit != '0) && (match_inc == {1'b0, limit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      j_s       <= 1'b0;
      zcnt      <= '0;
      zeros     <= '0;
      limit     <= '0;
      cfg_ok    <= 1'b0;
      cfg_err   <= 1'b0;
      match_cnt <= '0;
      Y         <= 1'b0;
      done      <= 1'b0;
    end else begin
      j_s  <= J;
      Y    <= 1'b0;
      done <= 1'b0;

      if (cfg_take) begin
        zeros   <= cfg_zeros;
        limit   <= cfg_limit;
        cfg_ok  <= (cfg_zeros != '0);
        cfg_err <= (cfg_zeros == '0);
      end

      if (abort) begin
        state <= StIdle;
      end else begin
        unique case (state)
          StIdle: begin
            // A start coinciding with a configuration offer is dropped.
            if (start && cfg_ok && !cfg_valid) begin
              state     <= StHunt;
              match_cnt <= '0;
            end
          end
          StHunt: begin
            if (j_s) state <= StSeen1;
          end
          StSeen1: begin
            if (!j_s) begin
              state <= StCount;
              zcnt  <= {{(CW-1){1'b0}}, 1'b1};
            end
          end
          StCount: begin
            if (j_s) begin
              if (zcnt == zeros) begin
                // Y, done and match_cnt are registered on entry so they align with HIT.
                state     <= StHit;
                Y         <= 1'b1;
                done      <= hit_next_done;
                match_cnt <= match_inc[MW] ? match_cnt : match_inc[MW-1:0];
              end else begin
                state <= StSeen1;
              end
            end else if (zcnt == zeros) begin
              state <= StHunt;
            end else begin
              zcnt <= zcnt + {{(CW-1){1'b0}}, 1'b1};
            end
          end
          StHit: begin
            if (done) begin
              state <= StIdle;
            end else if (j_s) begin
              state <= StSeen1;
            end else begin
              state <= StCount;
              zcnt  <= {{(CW-1){1'b0}}, 1'b1};
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;

  localparam int unsigned CW = 3;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          J = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_zeros = '0;
  logic [MW-1:0] cfg_limit = '0;
  logic          cfg_err;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          Y;
  logic          done;
  logic [MW-1:0] match_cnt;

  seq_detect_ctrl #(.CW(CW), .MW(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .J         (J),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_zeros (cfg_zeros),
    .cfg_limit (cfg_limit),
    .cfg_err   (cfg_err),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .Y         (Y),
    .done      (done),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic dn;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Match monitor: every Y pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (Y) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL y_unexpected: Y=1 at cycle %0d, none expected", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (cyc !== e.cyc || done !== e.dn) begin
            bad++;
            $display("FAIL y_pulse: got cycle=%0d done=%b, expected cycle=%0d done=%b",
                     cyc, done, e.cyc, e.dn);
          end
        end
      end else if (done) begin
        total++;
        bad++;
        $display("FAIL done_without_y: done=1 with Y=0 at cycle %0d", cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  // Present one serial bit; a 1 expected to close a match predicts Y two edges later.
  task automatic drive_bit(input logic b, input logic ab, input logic exp_y,
                           input logic exp_dn);
    J     = b;
    abort = ab;
    if (exp_y) sb.push_back('{cyc: cyc + 2, dn: exp_dn});
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  task automatic drive_zeros(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic configure(input logic [CW-1:0] n, input logic [MW-1:0] lim);
    cfg_valid = 1'b1;
    cfg_zeros = n;
    cfg_limit = lim;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_abort();
    drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_drained(input string name);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_y: %0d pulses outstanding, expected 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (Y !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 ||
        cfg_err !== 1'b0 || match_cnt !== '0) begin
      bad++;
      $display("FAIL reset_values: Y=%b done=%b busy=%b ready=%b err=%b cnt=%0d, expected 0 0 0 1 0 0",
               Y, done, busy, cfg_ready, cfg_err, match_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulse_start();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_start_unconfigured: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_basic();
    configure(3'd6, 4'd0);
    pulse_start();
    total++;
    if (busy !== 1'b1 || match_cnt !== 4'd0) begin
      bad++;
      $display("FAIL basic_start: busy=%b cnt=%0d, expected 1 0", busy, match_cnt);
    end
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    drive_zeros(6);
    drive_bit(1'b1, 1'b0, 1'b1, 1'b0);
    drive_zeros(3);
    total++;
    if (match_cnt !== 4'd1 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL basic_after: cnt=%0d busy=%b done=%b, expected 1 1 0",
               match_cnt, busy, done);
    end
    check_drained("basic");
    do_abort();
  endtask

  task automatic test_overlap_limit();
    configure(3'd6, 4'd2);
    pulse_start();
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    drive_zeros(6);
    drive_bit(1'b1, 1'b0, 1'b1, 1'b0);
    drive_zeros(6);
    drive_bit(1'b1, 1'b0, 1'b1, 1'b1);
    drive_zeros(3);
    total++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1 || match_cnt !== 4'd2) begin
      bad++;
      $display("FAIL overlap_limit_stop: busy=%b ready=%b cnt=%0d, expected 0 1 2",
               busy, cfg_ready, match_cnt);
    end
    check_drained("overlap_limit");
  endtask

  task automatic test_run_length();
    configure(3'd6, 4'd0);
    pulse_start();
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    drive_zeros(7);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    drive_zeros(5);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    drive_zeros(6);
    drive_bit(1'b1, 1'b0, 1'b1, 1'b0);
    drive_zeros(2);
    total++;
    if (match_cnt !== 4'd1) begin
      bad++;
      $display("FAIL run_length_count: cnt=%0d, expected 1", match_cnt);
    end
    check_drained("run_length");
    do_abort();
  endtask

  task automatic test_bad_config();
    configure(3'd0, 4'd0);
    total++;
    if (cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL bad_cfg_err: cfg_err=%b, expected 1", cfg_err);
    end
    pulse_start();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL bad_cfg_start: busy=%b, expected 0", busy);
    end
    configure(3'd3, 4'd0);
    total++;
    if (cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL good_cfg_err: cfg_err=%b, expected 0", cfg_err);
    end
    // Start alongside a new configuration: config taken, start dropped.
    cfg_valid = 1'b1;
    cfg_zeros = 3'd2;
    start     = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    start     = 1'b0;
    total++;
    if (busy !== 1'b0 || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL cfg_with_start: busy=%b err=%b, expected 0 0", busy, cfg_err);
    end
    pulse_start();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL start_after_cfg: busy=%b, expected 1", busy);
    end
    // Three zeros must be rejected; two must match (the new N took effect).
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    drive_zeros(3);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    drive_zeros(2);
    drive_bit(1'b1, 1'b0, 1'b1, 1'b0);
    drive_zeros(3);
    check_drained("bad_config");
    do_abort();
  endtask

  task automatic test_abort();
    configure(3'd6, 4'd0);
    pulse_start();
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    drive_zeros(6);
    drive_bit(1'b1, 1'b0, 1'b1, 1'b0);
    drive_zeros(3);
    do_abort();
    total++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_idle: busy=%b ready=%b, expected 0 1", busy, cfg_ready);
    end
    drive_zeros(3);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    drive_zeros(3);
    total++;
    if (match_cnt !== 4'd1) begin
      bad++;
      $display("FAIL abort_count_hold: cnt=%0d, expected 1", match_cnt);
    end
    check_drained("abort");
  endtask

  task automatic test_async_reset();
    configure(3'd3, 4'd0);
    pulse_start();
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    drive_zeros(3);
    drive_bit(1'b1, 1'b0, 1'b1, 1'b0);
    drive_zeros(3);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (Y !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 ||
        cfg_err !== 1'b0 || match_cnt !== '0) begin
      bad++;
      $display("FAIL async_reset_values: Y=%b done=%b busy=%b ready=%b err=%b cnt=%0d, expected 0 0 0 1 0 0",
               Y, done, busy, cfg_ready, cfg_err, match_cnt);
    end
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    pulse_start();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_cfg_lost: busy=%b, expected 0", busy);
    end
    check_drained("async_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap_limit();
    test_run_length();
    test_bad_config();
    test_abort();
    test_async_reset();
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
